serial_eq_seq: RTL and testbench

- Sequential equality checker that compares two WIDTH-bit words one bit per cycle through a single 1-bit equality cell (a == b).
- Control is a small FSM with a start/busy/done handshake. It reports overall equality and the index of the first mismatching bit, scanning LSB first.
- Sits beside the datapath wherever a cheap multi-cycle compare is preferred over a WIDTH-bit parallel comparator.

---
 rtl/serial_eq_seq.sv | 153 +++++++++++++++
 tb/tb_serial_eq_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_eq_seq.sv
// serial_eq_seq: bit-serial equality checker for two WIDTH-bit operands.
// One 1-bit equality cell is time-shared over WIDTH cycles, LSB first.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        compare request, accepted only while idle (busy=0)
//   a, b         operands, captured on the accepting edge only
//   busy         high while a compare is running or reporting (RUN/DONE)
//   done         one-cycle pulse; results are valid from this cycle on
//   equal        1 when every compared bit matched
//   mismatch_idx index of the lowest mismatching bit, 0 when equal=1
//
// Build option: define SERIAL_EQ_EARLY_EXIT_EN to end the scan at the
// first mismatching bit instead of always scanning all WIDTH bits.
// Reported results are the same either way; only latency differs.

module serial_eq_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic [CNT_W-1:0] mismatch_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_mism;
    logic             r_eq_acc;
    logic             r_first_seen;
    logic             r_equal;
    logic [CNT_W-1:0] r_mism_out;

    logic             w_accept;
    logic             w_run;
    logic             w_bit_eq;
    logic             w_new_mism;
    logic             w_last;
    logic             w_stop;
    logic             w_fin_eq;
    logic [CNT_W-1:0] w_fin_mism;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_run      = (r_state == S_RUN);

    // The single shared equality cell.
    assign w_bit_eq   = (r_sa[0] == r_sb[0]);

    assign w_new_mism = w_run && !w_bit_eq && !r_first_seen;
    assign w_last     = (r_idx == LAST_IDX);

`ifdef SERIAL_EQ_EARLY_EXIT_EN
    assign w_stop     = w_run && (w_last || w_new_mism);
`else
    assign w_stop     = w_run && w_last;
`endif

    // Final results fold in the bit being compared on the stopping edge,
    // since the accumulators only see it one edge later.
    assign w_fin_eq   = r_eq_acc && w_bit_eq;
    assign w_fin_mism = w_new_mism ? r_idx : r_mism;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_stop) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa         <= '0;
            r_sb         <= '0;
            r_idx        <= '0;
            r_mism       <= '0;
            r_eq_acc     <= 1'b0;
            r_first_seen <= 1'b0;
            r_equal      <= 1'b0;
            r_mism_out   <= '0;
        end else if (w_accept) begin
            r_sa         <= a;
            r_sb         <= b;
            r_idx        <= '0;
            r_mism       <= '0;
            r_eq_acc     <= 1'b1;
            r_first_seen <= 1'b0;
        end else if (w_run) begin
            if (w_new_mism) begin
                r_mism       <= r_idx;
                r_first_seen <= 1'b1;
                r_eq_acc     <= 1'b0;
            end
            r_sa <= r_sa >> 1;
            r_sb <= r_sb >> 1;
            // Hold the index on the last edge so it never wraps.
            if (!w_stop) begin
                r_idx <= r_idx + CNT_W'(1);
            end
            if (w_stop) begin
                r_equal    <= w_fin_eq;
                r_mism_out <= w_fin_mism;
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign equal        = r_equal;
    assign mismatch_idx = r_mism_out;

endmodule

// File: tb/tb_serial_eq_seq.sv
// tb_serial_eq_seq: directed bench for serial_eq_seq (WIDTH=8, CNT_W=3).
// Expected results come from a bit-loop model queued at each start.

module tb_serial_eq_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             equal;
    logic [CNT_W-1:0] mismatch_idx;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic             eq;
        logic [CNT_W-1:0] idx;
        int               lat;
    } exp_t;

    exp_t sb_q[$];

    serial_eq_seq #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .equal       (equal),
        .mismatch_idx(mismatch_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y);
        exp_t e;
        logic found;
        e.eq  = 1'b1;
        e.idx = '0;
        e.lat = WIDTH + 1;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!found && (x[i] !== y[i])) begin
                found = 1'b1;
                e.eq  = 1'b0;
                e.idx = i[CNT_W-1:0];
`ifdef SERIAL_EQ_EARLY_EXIT_EN
                e.lat = i + 2;
`endif
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Runs one compare; n counts edges from the accepting edge (n=1
    // right after it). Optionally overwrites a at negedge chg_at.
    task automatic run_cmp(input logic [WIDTH-1:0] ta,
                           input logic [WIDTH-1:0] tb_v,
                           input int chg_at,
                           input logic [WIDTH-1:0] chg_a);
        exp_t e;
        int n;
        int nb;
        sb_q.push_back(model(ta, tb_v));
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n  = 1;
        nb = 0;
        while (!done && n < 40) begin
            if (busy) nb++;
            if (n == chg_at) a = chg_a;
            @(negedge clk);
            n++;
        end
        if (busy) nb++;
        e = sb_q.pop_front();
        check("done_seen", {31'd0, done}, 32'd1);
        check("equal", {31'd0, equal}, {31'd0, e.eq});
        check("mismatch_idx", {29'd0, mismatch_idx}, {29'd0, e.idx});
        check("latency", n, e.lat);
        check("busy_cycles", nb, e.lat);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n_done;
        int first_at;
        int second_at;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_equal", {31'd0, equal}, 32'd0);
        check("rst_idx", {29'd0, mismatch_idx}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmp(8'hA5, 8'hA5, 0, 8'h00);
        run_cmp(8'hA5, 8'hA4, 0, 8'h00);
        run_cmp(8'h80, 8'h00, 0, 8'h00);
        run_cmp(8'hF0, 8'h00, 0, 8'h00);
        run_cmp(8'h5A, 8'h5A, 3, 8'hFF);

        // start held high: second accept only at the first IDLE edge.
        @(negedge clk);
        a         = 8'h11;
        b         = 8'h11;
        start     = 1'b1;
        n_done    = 0;
        first_at  = 0;
        second_at = 0;
        for (int n = 1; n <= 19; n++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_at == 0) first_at = n;
                else second_at = n;
                check("held_equal", {31'd0, equal}, 32'd1);
            end
            if (n == 10) check("held_gap_idle", {31'd0, busy}, 32'd0);
            if (n == 19) start = 1'b0;
        end
        check("held_done_count", n_done, 2);
        check("held_first_done", first_at, 9);
        check("held_second_done", second_at, 19);
        @(negedge clk);
        @(negedge clk);
        check("held_no_third", {31'd0, busy}, 32'd0);

        // Reset mid-RUN, just before edge 4 after accept.
        @(negedge clk);
        a     = 8'h0F;
        b     = 8'h0F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_equal", {31'd0, equal}, 32'd0);
        check("abort_idx", {29'd0, mismatch_idx}, 32'd0);
        #9;
        rst_n  = 1'b1;
        n_done = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);

        run_cmp(8'h08, 8'h00, 0, 8'h00);

        // Results hold while idle, even with operands wiggling.
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            check("hold_equal", {31'd0, equal}, 32'd0);
            check("hold_idx", {29'd0, mismatch_idx}, 32'd3);
        end

        run_cmp(8'h3C, 8'h3C, 0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
